data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder for the RV32I single-cycle core.
- Services the control unit's memory command (mem_rw: 10 = read, 01 = write) using the instruction's funct3 and the ALU-computed address.
- Performs byte/half/word loads with sign or zero extension, and stores with byte lanes.
- Stalls the PC until the access completes; flags misaligned or illegal accesses.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the internal array; power of two, ≥4.
- LATENCY, 2: BUSY cycles before the array access; ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mem_rw  in  2  command: 00 none, 10 read, 01 write, 11 treated as none
- funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address (ALU output)
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC/register writes while high
- done  out  1  one-cycle pulse: access complete; rdata valid for loads
- rdata  out  32  extended load result, registered
- misalign  out  1  one-cycle pulse: request rejected, no access performed

Behaviour:
- Reset (asynchronous, rst_n = 0): state = IDLE, rdata = 0, done = 0, misalign = 0, internal latches cleared. Array contents are not reset.
- Reset mid-operation: aborts the access; no write is committed.
- Valid request: mem_rw is 10 or 01, sampled only in IDLE. Inputs are ignored in BUSY and DONE.
- Alignment and legality check, applied in IDLE:
  - funct3[1:0] = 01 needs addr[0] = 0.
  - funct3[1:0] = 10 needs addr[1:0] = 00.
  - funct3[1:0] = 11 is illegal.
  - A store with funct3[2] = 1 is illegal.
- Rejected request: misalign = 1 on the next cycle for exactly one cycle; state stays IDLE; stall = 0; no array access.
- State IDLE:
  - stall = 1 combinationally when a valid, legal request is present.
  - On the clock edge: latch op, funct3, addr, wdata; counter = LATENCY-1; go to BUSY.
- State BUSY:
  - stall = 1.
  - While counter ≠ 0, decrement each cycle.
  - At counter = 0, on the clock edge:
    - Store: write the selected lanes.
    - Load: capture the extended result into rdata.
    - Go to DONE.
- State DONE:
  - done = 1, stall = 0 (the core advances this cycle). Go to IDLE next cycle.
  - A request present in DONE is not accepted.
  - Back-to-back accesses therefore restart from IDLE.
- Timing: request presented in cycle N → stall high in cycles N..N+LATENCY → done in cycle N+LATENCY+1.
- rdata holds its value until the next load completes; stores do not alter it.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Store lanes:
  - SB: lane addr[1:0] ← wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0].
  - SW: all lanes ← wdata.
- Load extraction:
  - LB / LBU: byte at lane addr[1:0], sign- / zero-extended to 32 bits.
  - LH / LHU: halfword at addr[1], sign- / zero-extended.
  - LW: full word.
- Outputs are mutually exclusive: done and misalign are never high in the same cycle.

Test Plan:
- Reset with rst_n low mid-BUSY during an SW to 0x10 → stall = 0, done = 0, rdata = 0 immediately; later LW 0x10 returns the prior contents (no write committed).
- SW 0x10 with wdata 0xDEADBEEF, LATENCY = 2 → stall high 3 cycles, done in cycle 4. Then LW 0x10 → rdata = 0xDEADBEEF.
- After that SW: SB 0x11 with wdata 0x80; LB 0x11 → rdata = 0xFFFFFF80; LBU 0x11 → rdata = 0x00000080; LW 0x10 → rdata = 0xDEAD80EF.
- SH 0x12 with wdata 0x00009234; LH 0x12 → rdata = 0xFFFF9234; LHU 0x12 → rdata = 0x00009234.
- LW 0x13, LH 0x11, and store funct3 = 100 → each gives a single misalign pulse, stall = 0, no done, memory unchanged.
- With DEPTH_WORDS = 256: SW 0x400 with wdata 0x12345678 → LW 0x0 returns 0x12345678 (wrap). mem_rw = 11 → no stall, no done.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for an RV32I core: byte/half/word loads and
// stores with a fixed access latency, PC stall while busy and misalignment rejection.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_rw,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_wr;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_rd, req_wr, req, legal, access, write_en;
  logic [AW-1:0]   idx;
  logic [31:0]     word, load_val;
  logic [3:0]      lane_en;
  logic            unused_bits;

  assign unused_bits = ^addr[31:AW+2];

  assign req_rd = (mem_rw == 2'b10);
  assign req_wr = (mem_rw == 2'b01);
  assign req    = req_rd | req_wr;

  always_comb begin
    legal = 1'b1;
    case (funct3[1:0])
      2'b01:   if (addr[0]) legal = 1'b0;
      2'b10:   if (addr[1:0] != 2'b00) legal = 1'b0;
      2'b11:   legal = 1'b0;
      default: legal = 1'b1;
    endcase
    if (req_wr && funct3[2]) legal = 1'b0;
  end

  assign stall    = (state == BUSY) || (state == IDLE && req && legal);
  assign access   = (state == BUSY) && (cnt == '0);
  assign write_en = access && op_wr && rst_n;
  assign idx      = addr_q[AW+1:2];
  assign word     = mem[idx];

  always_comb begin
    lane_en = '0;
    case (f3_q[1:0])
      2'b00:   lane_en[addr_q[1:0]] = 1'b1;
      2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = '1;
    endcase
  end

  // Store data is replicated across lanes so lane_en alone selects the target bytes.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          case (f3_q[1:0])
            2'b00:   mem[idx][8*i +: 8] <= wdata_q[7:0];
            2'b01:   mem[idx][8*i +: 8] <= wdata_q[8*(i%2) +: 8];
            default: mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
          endcase
        end
      end
    end
  end

  always_comb begin
    load_val = word;
    case (f3_q[1:0])
      2'b00: begin
        load_val = {24'b0, word[8*addr_q[1:0] +: 8]};
        if (!f3_q[2] && load_val[7]) load_val[31:8] = '1;
      end
      2'b01: begin
        load_val = {16'b0, word[16*addr_q[1] +: 16]};
        if (!f3_q[2] && load_val[15]) load_val[31:16] = '1;
      end
      default: load_val = word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      misalign <= 1'b0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (req && legal) begin
            op_wr   <= req_wr;
            f3_q    <= funct3;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            cnt     <= CW'(LATENCY - 1);
            state   <= BUSY;
          end else if (req) begin
            misalign <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!op_wr) rdata <= load_val;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected completions are queued at issue
// and compared when done/misalign pulses appear.
module tb_data_mem_responder;

  localparam int unsigned LAT = 2;

  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_MIS   = 2;
  localparam int K_NONE  = 3;

  typedef struct {
    int          kind;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mem_rw = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall, done, misalign;
  logic [31:0] rdata;

  exp_t        sb[$];
  logic [31:0] last_rdata = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rw(mem_rw), .funct3(funct3), .addr(addr),
    .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pop and compare every completion or rejection pulse against the queue.
  always @(negedge clk) begin
    if (rst_n && (done || misalign)) begin
      check_eq("exclusive", {31'b0, done & misalign}, 32'h0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {30'b0, done, misalign}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.kind == K_MIS) begin
          check_eq("misalign_kind", {31'b0, misalign}, 32'h1);
          check_eq("misalign_stall", {31'b0, stall}, 32'h0);
        end else begin
          check_eq("done_kind", {31'b0, done}, 32'h1);
          check_eq("done_stall", {31'b0, stall}, 32'h0);
          check_eq(e.kind == K_LOAD ? "load_rdata" : "store_keeps_rdata", rdata, e.rdata);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] rw, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int kind, input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    bit   seen;
    @(posedge clk); #1;
    mem_rw = rw; funct3 = f3; addr = a; wdata = wd;
    if (kind == K_LOAD) last_rdata = exp_rd;
    e.kind = kind;
    e.rdata = last_rdata;
    if (kind != K_NONE) sb.push_back(e);
    @(negedge clk);
    check_eq("stall_at_request", {31'b0, stall}, {31'b0, kind == K_LOAD || kind == K_STORE});
    @(posedge clk); #1;
    mem_rw = 2'b00;
    if (kind == K_LOAD || kind == K_STORE) begin
      n = 0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin seen = 1; break; end
        if (stall) n++;
      end
      check_eq("done_seen", {31'b0, seen}, 32'h1);
      check_eq("busy_stall_cycles", n, LAT);
    end else begin
      @(negedge clk);
      check_eq("no_done", {31'b0, done}, 32'h0);
      check_eq("no_stall", {31'b0, stall}, 32'h0);
      check_eq("misalign_pulse", {31'b0, misalign}, {31'b0, kind == K_MIS});
      @(negedge clk);
      check_eq("misalign_one_cycle", {31'b0, misalign}, 32'h0);
    end
  endtask

  initial begin
    #12;
    check_eq("reset_stall", {31'b0, stall}, 32'h0);
    check_eq("reset_done", {31'b0, done}, 32'h0);
    check_eq("reset_misalign", {31'b0, misalign}, 32'h0);
    check_eq("reset_rdata", rdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(2'b01, 3'b010, 32'h10, 32'h1111_1111, K_STORE, '0);

    // Abort an SW mid-BUSY with reset; the old word must survive.
    @(posedge clk); #1;
    mem_rw = 2'b01; funct3 = 3'b010; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rw = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midbusy_reset_stall", {31'b0, stall}, 32'h0);
    check_eq("midbusy_reset_done", {31'b0, done}, 32'h0);
    check_eq("midbusy_reset_rdata", rdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    last_rdata = '0;
    issue(2'b10, 3'b010, 32'h10, '0, K_LOAD, 32'h1111_1111);

    issue(2'b01, 3'b010, 32'h10, 32'hDEAD_BEEF, K_STORE, '0);
    issue(2'b10, 3'b010, 32'h10, '0, K_LOAD, 32'hDEAD_BEEF);
    issue(2'b01, 3'b000, 32'h11, 32'h0000_0080, K_STORE, '0);
    issue(2'b10, 3'b000, 32'h11, '0, K_LOAD, 32'hFFFF_FF80);
    issue(2'b10, 3'b100, 32'h11, '0, K_LOAD, 32'h0000_0080);
    issue(2'b10, 3'b010, 32'h10, '0, K_LOAD, 32'hDEAD_80EF);
    issue(2'b01, 3'b001, 32'h12, 32'h0000_9234, K_STORE, '0);
    issue(2'b10, 3'b001, 32'h12, '0, K_LOAD, 32'hFFFF_9234);
    issue(2'b10, 3'b101, 32'h12, '0, K_LOAD, 32'h0000_9234);
    issue(2'b10, 3'b010, 32'h10, '0, K_LOAD, 32'h9234_80EF);
    issue(2'b10, 3'b000, 32'h13, '0, K_LOAD, 32'hFFFF_FF92);

    issue(2'b10, 3'b010, 32'h13, '0, K_MIS, '0);
    issue(2'b10, 3'b001, 32'h11, '0, K_MIS, '0);
    issue(2'b01, 3'b100, 32'h10, 32'hFFFF_FFFF, K_MIS, '0);
    issue(2'b01, 3'b010, 32'h12, 32'hFFFF_FFFF, K_MIS, '0);
    issue(2'b10, 3'b011, 32'h10, '0, K_MIS, '0);
    issue(2'b10, 3'b010, 32'h10, '0, K_LOAD, 32'h9234_80EF);

    issue(2'b01, 3'b010, 32'h400, 32'h1234_5678, K_STORE, '0);
    issue(2'b10, 3'b010, 32'h0, '0, K_LOAD, 32'h1234_5678);
    issue(2'b11, 3'b010, 32'h10, '0, K_NONE, '0);
    issue(2'b00, 3'b010, 32'h10, '0, K_NONE, '0);

    repeat (3) @(posedge clk);
    check_eq("scoreboard_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
